// File: rtl/fpu_pkg.sv
// Shared FPU definitions.
//   fp32_t    : binary32 field view (sign, biased exponent, fraction)
//   BIAS      : binary32 exponent bias
//   EXP_MAX   : all-ones exponent (inf/NaN class)
//   fmul_s1_t : multiplier stage-1 pipeline register contents
package fpu_pkg;

    typedef struct packed {
        logic        sign;
        logic [7:0]  exp;
        logic [22:0] man;
    } fp32_t;

    localparam int         BIAS    = 127;
    localparam logic [7:0] EXP_MAX = 8'hFF;

    // valid distinguishes a real product from the cleared post-reset contents,
    // so the first stage-2 result after reset reads as a clean zero.
    typedef struct packed {
        logic              valid;
        logic              sign;
        logic              zero;
        logic              inf;
        logic signed [9:0] exp;   // ea + eb - BIAS, before normalisation
        logic [47:0]       prod;  // full hidden-bit mantissa product
    } fmul_s1_t;

endpackage

// File: rtl/fmul_mant_mul.sv
// 24x24 -> 48-bit unsigned mantissa multiplier (combinational, stage 1).
//   a, b : 24-bit mantissas including the hidden bit
//   p    : exact 48-bit product
module fmul_mant_mul (
    input  logic [23:0] a,
    input  logic [23:0] b,
    output logic [47:0] p
);

    assign p = {24'h0, a} * {24'h0, b};

endmodule

// File: rtl/fmul_pipelined.sv
// IEEE-754 binary32 multiplier, 2-stage pipeline, one operand pair per cycle.
// Round-to-nearest-even, denormal inputs treated as zero, no denormal or NaN outputs.
//   clk       : rising-edge clock
//   rst_n     : asynchronous active-low reset, clears every pipeline register
//   src, sink : operands A and B
//   dest      : registered product, valid two edges after the operands are sampled
//   overflow  : result saturated to +/-inf (large exponent or inf/NaN input)
//   underflow : nonzero exact product flushed to +/-0
module fmul_pipelined
    import fpu_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] src,
    input  logic [31:0] sink,
    output logic [31:0] dest,
    output logic        overflow,
    output logic        underflow
);

    fp32_t a;
    fp32_t b;
    assign a = src;
    assign b = sink;

    // ---------------- stage 1: classify, add exponents, multiply mantissas
    logic [47:0] prod;
    fmul_s1_t    s1_next;
    fmul_s1_t    s1_reg;

    fmul_mant_mul u_mant_mul (
        .a ({1'b1, a.man}),
        .b ({1'b1, b.man}),
        .p (prod)
    );

    always_comb begin
        s1_next       = '0;
        s1_next.valid = 1'b1;
        s1_next.sign  = a.sign ^ b.sign;
        s1_next.zero  = (a.exp == 8'h00) || (b.exp == 8'h00);
        s1_next.inf   = (a.exp == EXP_MAX) || (b.exp == EXP_MAX);
        s1_next.exp   = {2'b00, a.exp} + {2'b00, b.exp} - 10'(BIAS);
        s1_next.prod  = prod;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_reg <= '0;
        end else begin
            s1_reg <= s1_next;
        end
    end

    // ---------------- stage 2: normalise, round, classify, pack
    logic               p47;
    logic [22:0]        frac_pre;
    logic               guard;
    logic               sticky;
    logic               round_up;
    logic               carry;
    logic [22:0]        frac_rnd;
    logic signed [10:0] exp_rnd;
    logic [31:0]        dest_next;
    logic               overflow_next;
    logic               underflow_next;

    always_comb begin
        // Product of two [1,2) mantissas lies in [1,4); P[47] selects the 1-bit right shift.
        p47      = s1_reg.prod[47];
        frac_pre = p47 ? s1_reg.prod[46:24] : s1_reg.prod[45:23];
        guard    = p47 ? s1_reg.prod[23] : s1_reg.prod[22];
        sticky   = p47 ? (|s1_reg.prod[22:0]) : (|s1_reg.prod[21:0]);
        round_up = guard & (sticky | frac_pre[0]);

        // The hidden bit is always 1 here, so only the fraction is rounded; a carry
        // out of it means the mantissa reached 2.0, i.e. fraction 0 with E+1.
        {carry, frac_rnd} = {1'b0, frac_pre} + 24'(round_up);
        exp_rnd = {s1_reg.exp[9], s1_reg.exp} + 11'(p47) + 11'(carry);

        dest_next      = '0;
        overflow_next  = 1'b0;
        underflow_next = 1'b0;
        if (!s1_reg.valid) begin
            dest_next = '0;
        end else if (s1_reg.zero) begin
            // Zero wins over inf: 0 * inf gives a signed zero, no flags.
            dest_next = {s1_reg.sign, 31'h0};
        end else if (s1_reg.inf || (exp_rnd >= 11'sd255)) begin
            dest_next     = {s1_reg.sign, EXP_MAX, 23'h0};
            overflow_next = 1'b1;
        end else if (exp_rnd <= 11'sd0) begin
            dest_next      = {s1_reg.sign, 31'h0};
            underflow_next = 1'b1;
        end else begin
            dest_next = {s1_reg.sign, exp_rnd[7:0], frac_rnd};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dest      <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            dest      <= dest_next;
            overflow  <= overflow_next;
            underflow <= underflow_next;
        end
    end

endmodule

// File: tb/tb_fmul_pipelined.sv
// Directed and swept-exponent checks for fmul_pipelined.
module tb_fmul_pipelined;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] src;
    logic [31:0] sink;
    logic [31:0] dest;
    logic        overflow;
    logic        underflow;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    fmul_pipelined dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .src       (src),
        .sink      (sink),
        .dest      (dest),
        .overflow  (overflow),
        .underflow (underflow)
    );

    // Independent reference: the exact product of two binary32 values fits in a
    // double, so one RNE step from double to binary32 gives the correct result.
    // Only used for operands whose product is a normal number.
    function automatic logic [31:0] ref_mul(input logic [31:0] a, input logic [31:0] b);
        logic [63:0] da, db, dp;
        real         prd;
        logic [23:0] keep;
        logic        g, st;
        logic [24:0] r;
        int          e;
        da   = {a[31], 11'({3'b000, a[30:23]} + 11'd896), a[22:0], 29'h0};
        db   = {b[31], 11'({3'b000, b[30:23]} + 11'd896), b[22:0], 29'h0};
        prd  = $bitstoreal(da) * $bitstoreal(db);
        dp   = $realtobits(prd);
        keep = {1'b1, dp[51:29]};
        g    = dp[28];
        st   = |dp[27:0];
        r    = {1'b0, keep} + 25'(g & (st | keep[0]));
        e    = int'(dp[62:52]) - 896;
        if (r[24]) begin
            e = e + 1;
            r = r >> 1;
        end
        return {dp[63], e[7:0], r[22:0]};
    endfunction

    // Drive one pair at a negedge and return what appears two edges later.
    task automatic run_one(input logic [31:0] a, input logic [31:0] b,
                           output logic [31:0] d, output logic o, output logic u);
        @(negedge clk);
        src  = a;
        sink = b;
        @(negedge clk);
        @(negedge clk);
        d = dest;
        o = overflow;
        u = underflow;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        src   = 32'h3F800000;
        sink  = 32'h40000000;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({dest, overflow, underflow} !== {32'h0, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL reset_state: dest=%h ovf=%b unf=%b, expected 00000000 0 0",
                     dest, overflow, underflow);
        end
        $display("reset_state dest=%h ovf=%b unf=%b", dest, overflow, underflow);
        rst_n = 1'b1;
        // One edge after release: stage 2 drains the cleared stage 1.
        @(negedge clk);
        n_checks++;
        if ({dest, overflow, underflow} !== {32'h0, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL reset_first_edge: dest=%h ovf=%b unf=%b, expected 00000000 0 0",
                     dest, overflow, underflow);
        end
        @(negedge clk);
        n_checks++;
        if ({dest, overflow, underflow} !== {32'h40000000, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL reset_first_result: dest=%h ovf=%b unf=%b, expected 40000000 0 0",
                     dest, overflow, underflow);
        end
        $display("reset_first_result dest=%h", dest);
    endtask

    task automatic test_basic();
        logic [31:0] va[3] = '{32'h3F800000, 32'h3FC00000, 32'hBFC00000};
        logic [31:0] vb[3] = '{32'h3F800000, 32'h40000000, 32'h40000000};
        logic [31:0] ve[3] = '{32'h3F800000, 32'h40400000, 32'hC0400000};
        logic [31:0] d;
        logic        o, u;
        for (int i = 0; i < 3; i++) begin
            run_one(va[i], vb[i], d, o, u);
            n_checks++;
            if ({d, o, u} !== {ve[i], 1'b0, 1'b0}) begin
                n_fail++;
                $display("FAIL basic[%0d] %h*%h: dest=%h ovf=%b unf=%b, expected %h 0 0",
                         i, va[i], vb[i], d, o, u, ve[i]);
            end
            $display("basic[%0d] %h*%h -> %h ovf=%b unf=%b", i, va[i], vb[i], d, o, u);
        end
    endtask

    task automatic test_rounding();
        // guard=0 sticky=1 down; guard=1 sticky=1 up; ties to odd lsb up / even lsb stay;
        // mantissa round-up carry into the exponent; P[47] case rounding down.
        logic [31:0] va[6] = '{32'h3F800001, 32'h3FC00001, 32'h3F800001,
                               32'h3F800003, 32'h3F918E00, 32'h3FFFFFFF};
        logic [31:0] vb[6] = '{32'h3F800001, 32'h3FC00001, 32'h3FC00000,
                               32'h3FC00000, 32'h3FE12000, 32'h3FFFFFFF};
        logic [31:0] ve[6] = '{32'h3F800002, 32'h40100002, 32'h3FC00002,
                               32'h3FC00004, 32'h40000000, 32'h407FFFFE};
        logic [31:0] d;
        logic        o, u;
        for (int i = 0; i < 6; i++) begin
            run_one(va[i], vb[i], d, o, u);
            n_checks++;
            if ({d, o, u} !== {ve[i], 1'b0, 1'b0}) begin
                n_fail++;
                $display("FAIL round[%0d] %h*%h: dest=%h ovf=%b unf=%b, expected %h 0 0",
                         i, va[i], vb[i], d, o, u, ve[i]);
            end
            $display("round[%0d] %h*%h -> %h", i, va[i], vb[i], d);
        end
    endtask

    task automatic test_special();
        logic [31:0] va[8] = '{32'h7F000000, 32'h00800000, 32'h80800000, 32'h00000000,
                               32'h00400000, 32'h7F800000, 32'h00000000, 32'h80000000};
        logic [31:0] vb[8] = '{32'h40000000, 32'h3F000000, 32'h3F000000, 32'h7F7FFFFF,
                               32'h3F800000, 32'hBF800000, 32'h7F800000, 32'h3F800000};
        logic [31:0] ve[8] = '{32'h7F800000, 32'h00000000, 32'h80000000, 32'h00000000,
                               32'h00000000, 32'hFF800000, 32'h00000000, 32'h80000000};
        logic        vo[8] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        logic        vu[8] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        logic [31:0] d;
        logic        o, u;
        for (int i = 0; i < 8; i++) begin
            run_one(va[i], vb[i], d, o, u);
            n_checks++;
            if ({d, o, u} !== {ve[i], vo[i], vu[i]}) begin
                n_fail++;
                $display("FAIL special[%0d] %h*%h: dest=%h ovf=%b unf=%b, expected %h %b %b",
                         i, va[i], vb[i], d, o, u, ve[i], vo[i], vu[i]);
            end
            $display("special[%0d] %h*%h -> %h ovf=%b unf=%b", i, va[i], vb[i], d, o, u);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] pend[$];
        logic [31:0] a, b, exp_d;
        for (int ea = 120; ea <= 149; ea++) begin
            for (int eb = 120; eb <= 149; eb++) begin
                @(negedge clk);
                if (pend.size() >= 2) begin
                    exp_d = pend.pop_front();
                    n_checks++;
                    if ({dest, overflow, underflow} !== {exp_d, 1'b0, 1'b0}) begin
                        n_fail++;
                        $display("FAIL stream: dest=%h ovf=%b unf=%b, expected %h 0 0",
                                 dest, overflow, underflow, exp_d);
                    end
                end
                a = {1'($urandom_range(1)), 8'(ea), 23'($urandom)};
                b = {1'($urandom_range(1)), 8'(eb), 23'($urandom)};
                src  = a;
                sink = b;
                pend.push_back(ref_mul(a, b));
            end
        end
        while (pend.size() > 0) begin
            @(negedge clk);
            exp_d = pend.pop_front();
            n_checks++;
            if ({dest, overflow, underflow} !== {exp_d, 1'b0, 1'b0}) begin
                n_fail++;
                $display("FAIL stream_drain: dest=%h ovf=%b unf=%b, expected %h 0 0",
                         dest, overflow, underflow, exp_d);
            end
        end
        $display("stream 900 pairs done");
    endtask

    task automatic test_midstream_reset();
        @(negedge clk);
        src  = 32'h3F800000;
        sink = 32'h40000000;
        repeat (3) @(negedge clk);
        n_checks++;
        if (dest !== 32'h40000000) begin
            n_fail++;
            $display("FAIL pre_reset: dest=%h, expected 40000000", dest);
        end
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({dest, overflow, underflow} !== {32'h0, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL async_reset: dest=%h ovf=%b unf=%b, expected 00000000 0 0",
                     dest, overflow, underflow);
        end
        $display("async_reset dest=%h", dest);
        @(negedge clk);
        src   = 32'h40400000;
        sink  = 32'h3F800000;
        rst_n = 1'b1;
        @(negedge clk);
        n_checks++;
        if (dest !== 32'h0) begin
            n_fail++;
            $display("FAIL post_reset_discard: dest=%h, expected 00000000", dest);
        end
        @(negedge clk);
        n_checks++;
        if (dest !== 32'h40400000) begin
            n_fail++;
            $display("FAIL post_reset_result: dest=%h, expected 40400000", dest);
        end
        $display("post_reset_result dest=%h", dest);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_rounding();
        test_special();
        test_back_to_back();
        test_midstream_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
